register_seq_ctrl: RTL and testbench

- Command sequencer for the 4-bit control-line register datapath (cl/ld/inc/dec/sr/sl).
- Accepts one command at a time over a valid/ready handshake and drives the register's one-hot control lines for 1..16 consecutive cycles.
- Signals completion with a one-cycle done pulse.
- Sits between a host FSM/bus and one register instance; reads the register output back for rotate and saturation decisions.

---
 rtl/register_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_register_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_seq_ctrl.sv
// Command sequencer for a 4-bit cl/ld/inc/dec/sr/sl register: one command per handshake,
// 1..2^CNT_W control cycles, then a one-cycle done pulse. Optional: REGISTER_SEQ_SATURATE_EN.
module register_seq_ctrl #(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [W-1:0]     cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [W-1:0]     reg_q,
    output logic             cl,
    output logic             ld,
    output logic             inc,
    output logic             dec,
    output logic             sr,
    output logic             sl,
    output logic [W-1:0]     in,
    output logic             ir,
    output logic             il,
    output logic             busy,
    output logic             done
`ifdef REGISTER_SEQ_SATURATE_EN
    ,
    output logic             sat
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    typedef enum logic [2:0] {
        OpNop, OpClr, OpLoad, OpInc, OpDec, OpShr, OpShl, OpRol
    } op_e;

    state_e           state_q;
    op_e              op_q;
    logic [W-1:0]     data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_stop;
    logic             repeats;
    logic             unused_reg_bits;

    assign unused_reg_bits = ^reg_q;

    // Only the shift/arith ops honour the repeat count; CLR/LOAD always run once.
    assign repeats = (cmd_op == OpInc) || (cmd_op == OpDec) || (cmd_op == OpShr) ||
                     (cmd_op == OpShl) || (cmd_op == OpRol);

`ifdef REGISTER_SEQ_SATURATE_EN
    logic sat_q;

    assign sat_stop = (state_q == StRun) &&
                      (((op_q == OpInc) && (reg_q == {W{1'b1}})) ||
                       ((op_q == OpDec) && (reg_q == {W{1'b0}})));
    assign sat      = (state_q == StDone) && sat_q;
`else
    assign sat_stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpNop;
            data_q  <= '0;
            cnt_q   <= '0;
`ifdef REGISTER_SEQ_SATURATE_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q    <= op_e'(cmd_op);
                        data_q  <= cmd_data;
                        cnt_q   <= repeats ? cmd_cnt : '0;
`ifdef REGISTER_SEQ_SATURATE_EN
                        sat_q   <= 1'b0;
`endif
                        state_q <= (cmd_op == OpNop) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (sat_stop) begin
`ifdef REGISTER_SEQ_SATURATE_EN
                        sat_q   <= 1'b1;
`endif
                        state_q <= StDone;
                    end else if (cnt_q == '0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Strobes decode from the latched op only; ROL's fill bit is the live register MSB.
    always_comb begin
        cl        = 1'b0;
        ld        = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
        sr        = 1'b0;
        sl        = 1'b0;
        in        = '0;
        ir        = 1'b0;
        il        = 1'b0;
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        if ((state_q == StRun) && !sat_stop) begin
            unique case (op_q)
                OpNop:  ;
                OpClr:  cl = 1'b1;
                OpLoad: begin
                    ld = 1'b1;
                    in = data_q;
                end
                OpInc:  inc = 1'b1;
                OpDec:  dec = 1'b1;
                OpShr: begin
                    sr = 1'b1;
                    ir = data_q[0];
                end
                OpShl: begin
                    sl = 1'b1;
                    il = data_q[0];
                end
                OpRol: begin
                    sl = 1'b1;
                    il = reg_q[W-1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_register_seq_ctrl.sv
// Self-checking bench for register_seq_ctrl: a behavioural 4-bit register closes the loop,
// a vector table covers single commands, hand sequences cover reset, back-to-back and busy.
module tb_register_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_data = 4'd0;
    logic [3:0] cmd_cnt = 4'd0;
    logic       cmd_ready, cl, ld, inc, dec, sr, sl, ir, il, busy, done;
    logic [3:0] in;
    logic [3:0] reg_q;
    logic       sat_obs;

    register_seq_ctrl #(.W(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .reg_q     (reg_q),
        .cl        (cl),
        .ld        (ld),
        .inc       (inc),
        .dec       (dec),
        .sr        (sr),
        .sl        (sl),
        .in        (in),
        .ir        (ir),
        .il        (il),
        .busy      (busy),
        .done      (done)
`ifdef REGISTER_SEQ_SATURATE_EN
        ,
        .sat       (sat_obs)
`endif
    );

`ifndef REGISTER_SEQ_SATURATE_EN
    assign sat_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    // The register the controller drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   reg_q <= 4'd0;
        else if (cl)  reg_q <= 4'd0;
        else if (ld)  reg_q <= in;
        else if (inc) reg_q <= reg_q + 4'd1;
        else if (dec) reg_q <= reg_q - 4'd1;
        else if (sr)  reg_q <= {ir, reg_q[3:1]};
        else if (sl)  reg_q <= {reg_q[2:0], il};
    end

    typedef struct {
        logic [2:0] op;
        logic [3:0] data;
        logic [3:0] cnt;
        int         cyc;
        int         line;
        int         str;
        int         fill;
        logic [3:0] reg_exp;
        bit         sat;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t_line[6];
    int   t_aux;
    int   t_fill;

    function automatic vec_t mk(input logic [2:0] op, input logic [3:0] data,
                                input logic [3:0] cnt, input int cyc, input int line,
                                input int str, input int fill, input logic [3:0] r,
                                input bit s);
        vec_t v;
        v.op = op; v.data = data; v.cnt = cnt; v.cyc = cyc; v.line = line;
        v.str = str; v.fill = fill; v.reg_exp = r; v.sat = s;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int line_sum();
        return int'(cl) + int'(ld) + int'(inc) + int'(dec) + int'(sr) + int'(sl);
    endfunction

    task automatic clear_tally();
        foreach (t_line[i]) t_line[i] = 0;
        t_aux  = 0;
        t_fill = 0;
    endtask

    // One RUN cycle observation: one-hot strobes, idle side data, handshake flags.
    task automatic tally(input logic [3:0] data);
        logic [5:0] lines;
        lines = {sl, sr, dec, inc, ld, cl};
        for (int i = 0; i < 6; i++) t_line[i] += int'(lines[i]);
        if ($countones(lines) > 1) t_aux++;
        if (!ld && in != 4'd0) t_aux++;
        if (ld && in != data) t_aux++;
        if (!sr && ir) t_aux++;
        if (!sl && il) t_aux++;
        if (!busy || cmd_ready || done || sat_obs) t_aux++;
        if ((sr && ir) || (sl && il)) t_fill++;
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        int guard;
        int sum;
        cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data; cmd_cnt = v.cnt;
        guard = 0;
        while (!cmd_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("v%0d accept", idx), int'(guard < 40), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        clear_tally();
        guard = 0;
        while (!done && guard < 40) begin
            tally(v.data);
            @(negedge clk);
            guard++;
        end
        sum = 0;
        for (int i = 0; i < 6; i++) sum += t_line[i];
        check($sformatf("v%0d run cycles", idx), guard, v.cyc);
        check($sformatf("v%0d strobes", idx), t_line[v.line], v.str);
        check($sformatf("v%0d total strobes", idx), sum, v.str);
        check($sformatf("v%0d side signals", idx), t_aux, 0);
        check($sformatf("v%0d fill bits", idx), t_fill, v.fill);
        check($sformatf("v%0d done flags", idx),
              {busy, cmd_ready, line_sum() == 0}, {1'b1, 1'b0, 1'b1});
        check($sformatf("v%0d sat", idx), int'(sat_obs), int'(v.sat));
        @(negedge clk);
        check($sformatf("v%0d idle flags", idx), {done, cmd_ready, busy, sat_obs}, 4'b0100);
        check($sformatf("v%0d register", idx), reg_q, v.reg_exp);
    endtask

    initial begin
        int guard;
        int n_sl;
        int n_other;
        int n_il;
        int n_done;
        int n_nready;

        // op codes: 0 NOP 1 CLR 2 LOAD 3 INC 4 DEC 5 SHR 6 SHL 7 ROL; lines cl,ld,inc,dec,sr,sl
        vecs.push_back(mk(3'd2, 4'd5,  4'd9, 1, 1, 1, 0, 4'd5,  1'b0));
        vecs.push_back(mk(3'd3, 4'd0,  4'd2, 3, 2, 3, 0, 4'd8,  1'b0));
        vecs.push_back(mk(3'd2, 4'd9,  4'd0, 1, 1, 1, 0, 4'd9,  1'b0));
        vecs.push_back(mk(3'd7, 4'd0,  4'd0, 1, 5, 1, 1, 4'd3,  1'b0));
        vecs.push_back(mk(3'd5, 4'd1,  4'd1, 2, 4, 2, 2, 4'd12, 1'b0));
        vecs.push_back(mk(3'd1, 4'd7,  4'd5, 1, 0, 1, 0, 4'd0,  1'b0));
`ifdef REGISTER_SEQ_SATURATE_EN
        vecs.push_back(mk(3'd4, 4'd0,  4'd0, 1, 3, 0, 0, 4'd0,  1'b1));
`else
        vecs.push_back(mk(3'd4, 4'd0,  4'd0, 1, 3, 1, 0, 4'd15, 1'b0));
`endif
        vecs.push_back(mk(3'd6, 4'd0,  4'd3, 4, 5, 4, 0, 4'd0,  1'b0));
        vecs.push_back(mk(3'd0, 4'd9,  4'd4, 0, 0, 0, 0, 4'd0,  1'b0));
        vecs.push_back(mk(3'd2, 4'd14, 4'd0, 1, 1, 1, 0, 4'd14, 1'b0));
`ifdef REGISTER_SEQ_SATURATE_EN
        vecs.push_back(mk(3'd3, 4'd0,  4'd5, 2, 2, 1, 0, 4'd15, 1'b1));
        vecs.push_back(mk(3'd2, 4'd1,  4'd0, 1, 1, 1, 0, 4'd1,  1'b0));
        vecs.push_back(mk(3'd4, 4'd0,  4'd3, 2, 3, 1, 0, 4'd0,  1'b1));
        vecs.push_back(mk(3'd3, 4'd0,  4'd15, 16, 2, 15, 0, 4'd15, 1'b1));
        vecs.push_back(mk(3'd7, 4'd0,  4'd2, 3, 5, 3, 3, 4'd15, 1'b0));
`else
        vecs.push_back(mk(3'd3, 4'd0,  4'd3, 4, 2, 4, 0, 4'd2,  1'b0));
        vecs.push_back(mk(3'd2, 4'd1,  4'd0, 1, 1, 1, 0, 4'd1,  1'b0));
        vecs.push_back(mk(3'd4, 4'd0,  4'd3, 4, 3, 4, 0, 4'd13, 1'b0));
        vecs.push_back(mk(3'd3, 4'd0,  4'd15, 16, 2, 16, 0, 4'd13, 1'b0));
        vecs.push_back(mk(3'd7, 4'd0,  4'd2, 3, 5, 3, 2, 4'd14, 1'b0));
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("reset flags", {cmd_ready, busy, done, sat_obs}, 4'b1000);
        check("reset lines", line_sum() + int'(in) + int'(ir) + int'(il), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset ready", int'(cmd_ready), 1);

        // Reset on the 3rd RUN cycle of INC cnt=7 aborts without a done pulse
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_data = 4'd0; cmd_cnt = 4'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort run1 inc", int'(inc), 1);
        repeat (2) @(negedge clk);
        check("abort run3 inc", {inc, busy}, 2'b11);
        #1 rst_n = 1'b0;
        #1;
        check("abort async lines", line_sum() + int'(in) + int'(ir) + int'(il), 0);
        check("abort async flags", {cmd_ready, busy, done, sat_obs}, 4'b1000);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0; n_nready = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_done += int'(done);
            n_nready += int'(!cmd_ready);
        end
        check("abort no done", n_done, 0);
        check("abort ready held", n_nready, 0);

        foreach (vecs[i]) run_cmd(vecs[i], i);

        // Back-to-back: valid held high, CLR then DEC cnt=0
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 4'd0; cmd_cnt = 4'd0;
        @(negedge clk);
        check("b2b clr", {cl, dec}, 2'b10);
        cmd_op = 3'd4;
        @(negedge clk);
        check("b2b done1", {done, dec, cmd_ready}, 3'b100);
        @(negedge clk);
        check("b2b ready", {cmd_ready, busy, dec}, 3'b100);
        @(negedge clk);
        cmd_valid = 1'b0;
`ifdef REGISTER_SEQ_SATURATE_EN
        check("b2b dec strobe", {dec, busy}, 2'b01);
`else
        check("b2b dec strobe", {dec, busy}, 2'b11);
`endif
        @(negedge clk);
`ifdef REGISTER_SEQ_SATURATE_EN
        check("b2b done2", {done, sat_obs}, 2'b11);
`else
        check("b2b done2", {done, sat_obs}, 2'b10);
`endif
        @(negedge clk);
`ifdef REGISTER_SEQ_SATURATE_EN
        check("b2b register", reg_q, 0);
`else
        check("b2b register", reg_q, 15);
`endif

        // SHL cnt=3 fill 1 while the host scribbles on cmd_* during RUN
        cmd_valid = 1'b1; cmd_op = 3'd6; cmd_data = 4'd1; cmd_cnt = 4'd3;
        @(negedge clk);
        n_sl = 0; n_other = 0; n_il = 0; guard = 0;
        while (!done && guard < 20) begin
            n_sl += int'(sl);
            n_il += int'(il);
            n_other += line_sum() - int'(sl);
            cmd_op = 3'(guard * 3 + 1);
            cmd_data = 4'b0110 ^ 4'(guard);
            cmd_cnt = 4'd15;
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b0;
        check("busy-ignore cycles", guard, 4);
        check("busy-ignore sl count", n_sl, 4);
        check("busy-ignore il count", n_il, 4);
        check("busy-ignore other", n_other, 0);
        @(negedge clk);
        check("busy-ignore register", reg_q, 15);
        check("busy-ignore idle", {cmd_ready, busy, done}, 3'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
